window_controller: RTL and testbench

- Control and read-out side of the `line_buffer` array in the Canny front end.
- Accepts the raster pixel stream and steers each image line into one of four line buffers in round-robin order.
- Once three full lines are stored, issues read strobes to those three buffers and assembles their 3-pixel row slices into a registered 3x3 window for the Sobel stage.
- Signals completion of each window row and back-pressures the pixel source when all four buffers hold unread lines.

---
 rtl/definitions_pkg.sv | 32 +++
 rtl/window_row_mux.sv | 54 +++++
 rtl/window_controller.sv | 152 +++++++++++++++
 tb/tb_window_controller.sv | 324 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/definitions_pkg.sv
// Shared constants and types for the Canny front end line-buffer path.
// Also holds the line-buffer select decoders used by the window controller.
package definitions_pkg;

    localparam int IMAGE_WIDTH = 512;
    localparam int NUM_LB      = 4;

    typedef enum logic {
        RD_IDLE   = 1'b0,
        RD_ACTIVE = 1'b1
    } rd_state_t;

    typedef logic [23:0] row_slice_t;

    function automatic logic [3:0] lb_onehot(input logic [1:0] sel);
        logic [3:0] mask;
        case (sel)
            2'd0:    mask = 4'b0001;
            2'd1:    mask = 4'b0010;
            2'd2:    mask = 4'b0100;
            2'd3:    mask = 4'b1000;
            default: mask = 4'b0000;
        endcase
        return mask;
    endfunction

    // The three buffers read together start at sel and wrap modulo four.
    function automatic logic [3:0] lb_read_mask(input logic [1:0] sel);
        return lb_onehot(sel) | lb_onehot(sel + 2'd1) | lb_onehot(sel + 2'd2);
    endfunction

endpackage

// File: rtl/window_row_mux.sv
// Rotates the four line-buffer row slices so the oldest stored line
// (selected by rd_sel) lands in the top row of the window.
module window_row_mux
    import definitions_pkg::*;
(
    input  logic [23:0] data0,
    input  logic [23:0] data1,
    input  logic [23:0] data2,
    input  logic [23:0] data3,
    input  logic [1:0]  rd_sel,
    output logic [71:0] window
);

    row_slice_t top_s;
    row_slice_t mid_s;
    row_slice_t bot_s;

    // Pick top/mid/bottom slices by rotation of the read pointer
    always_comb begin
        top_s = 24'd0;
        mid_s = 24'd0;
        bot_s = 24'd0;
        case (rd_sel)
            2'd0: begin
                top_s = data0;
                mid_s = data1;
                bot_s = data2;
            end
            2'd1: begin
                top_s = data1;
                mid_s = data2;
                bot_s = data3;
            end
            2'd2: begin
                top_s = data2;
                mid_s = data3;
                bot_s = data0;
            end
            2'd3: begin
                top_s = data3;
                mid_s = data0;
                bot_s = data1;
            end
            default: begin
                top_s = 24'd0;
                mid_s = 24'd0;
                bot_s = 24'd0;
            end
        endcase
    end

    assign window = {top_s, mid_s, bot_s};

endmodule

// File: rtl/window_controller.sv
// Steers the raster stream into four round-robin line buffers and reads three
// stored lines back as a registered 3x3 window for the Sobel stage.
module window_controller
    import definitions_pkg::rd_state_t, definitions_pkg::RD_IDLE, definitions_pkg::RD_ACTIVE,
           definitions_pkg::lb_onehot, definitions_pkg::lb_read_mask;
#(
    parameter int IMAGE_WIDTH = definitions_pkg::IMAGE_WIDTH,
    parameter int NUM_LB      = definitions_pkg::NUM_LB
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        i_pixel,
    input  logic              i_pixel_valid,
    output logic              o_pixel_ready,
    output logic [NUM_LB-1:0] o_lb_wr_valid,
    output logic [NUM_LB-1:0] o_lb_rd,
    input  logic [23:0]       i_lb_data0,
    input  logic [23:0]       i_lb_data1,
    input  logic [23:0]       i_lb_data2,
    input  logic [23:0]       i_lb_data3,
    output logic [71:0]       o_window,
    output logic              o_window_valid,
    output logic              o_line_done
);

    localparam int CNT_W = $clog2(IMAGE_WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(IMAGE_WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_VLAST = CNT_W'(IMAGE_WIDTH - 3);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    logic [1:0]       wr_sel_r;
    logic [1:0]       rd_sel_r;
    logic [CNT_W-1:0] wr_cnt_r;
    logic [CNT_W-1:0] rd_cnt_r;
    logic [2:0]       lines_stored_r;
    rd_state_t        rd_state_r;
    rd_state_t        rd_state_s;
    logic             accept_s;
    logic             line_written_s;
    logic             line_read_s;
    logic             win_valid_s;
    logic [71:0]      win_mux_s;

    // i_pixel is not consumed here: the buffers take it straight from the source.
    // Strobes are masked during reset so the buffers never see a write while held.
    assign o_pixel_ready  = (lines_stored_r != 3'd4);
    assign accept_s       = i_pixel_valid & o_pixel_ready & ~rst;
    assign o_lb_wr_valid  = lb_onehot(wr_sel_r) & {4{accept_s}};
    assign line_written_s = accept_s & (wr_cnt_r == CNT_LAST);
    assign line_read_s    = (rd_state_r == RD_ACTIVE) & (rd_cnt_r == CNT_LAST);
    assign win_valid_s    = (rd_state_r == RD_ACTIVE) & (rd_cnt_r <= CNT_VLAST);

    window_row_mux u_row_mux (
        .data0  (i_lb_data0),
        .data1  (i_lb_data1),
        .data2  (i_lb_data2),
        .data3  (i_lb_data3),
        .rd_sel (rd_sel_r),
        .window (win_mux_s)
    );

    // Read FSM next state and Moore read strobes
    always_comb begin
        rd_state_s = rd_state_r;
        o_lb_rd    = 4'b0000;
        case (rd_state_r)
            RD_IDLE: begin
                if (lines_stored_r >= 3'd3) begin
                    rd_state_s = RD_ACTIVE;
                end else begin
                    rd_state_s = RD_IDLE;
                end
            end
            RD_ACTIVE: begin
                o_lb_rd = lb_read_mask(rd_sel_r);
                if (line_read_s) begin
                    rd_state_s = RD_IDLE;
                end else begin
                    rd_state_s = RD_ACTIVE;
                end
            end
            default: begin
                rd_state_s = RD_IDLE;
                o_lb_rd    = 4'b0000;
            end
        endcase
    end

    // Read FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_state_r <= RD_IDLE;
        end else begin
            rd_state_r <= rd_state_s;
        end
    end

    // Write column counter and round-robin write buffer pointer
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_cnt_r <= '0;
            wr_sel_r <= 2'd0;
        end else if (line_written_s) begin
            wr_cnt_r <= '0;
            wr_sel_r <= wr_sel_r + 2'd1;
        end else if (accept_s) begin
            wr_cnt_r <= wr_cnt_r + CNT_ONE;
        end
    end

    // Read column counter and oldest-line pointer
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_cnt_r <= '0;
            rd_sel_r <= 2'd0;
        end else if (line_read_s) begin
            rd_cnt_r <= '0;
            rd_sel_r <= rd_sel_r + 2'd1;
        end else if (rd_state_r == RD_ACTIVE) begin
            rd_cnt_r <= rd_cnt_r + CNT_ONE;
        end
    end

    // Count of fully written, not yet read lines
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lines_stored_r <= 3'd0;
        end else begin
            case ({line_written_s, line_read_s})
                2'b10:   lines_stored_r <= lines_stored_r + 3'd1;
                2'b01:   lines_stored_r <= lines_stored_r - 3'd1;
                default: lines_stored_r <= lines_stored_r;
            endcase
        end
    end

    // Registered window; the last two strobes straddle the buffer wrap and are dropped
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            o_window       <= 72'd0;
            o_window_valid <= 1'b0;
            o_line_done    <= 1'b0;
        end else begin
            o_window_valid <= win_valid_s;
            o_line_done    <= line_read_s;
            if (win_valid_s) begin
                o_window <= win_mux_s;
            end
        end
    end

endmodule

// File: tb/tb_window_controller.sv
// Directed bench for window_controller with IMAGE_WIDTH=8 and four behavioural
// line buffers; pixel value is 16*row + col.
module tb_window_controller;

    localparam int W = 8;

    logic        clk;
    logic        rst;
    logic [7:0]  i_pixel;
    logic        i_pixel_valid;
    logic        o_pixel_ready;
    logic [3:0]  o_lb_wr_valid;
    logic [3:0]  o_lb_rd;
    logic [23:0] lb_data [4];
    logic [71:0] o_window;
    logic        o_window_valid;
    logic        o_line_done;

    logic [7:0]  mem [4][W];
    int          wp [4];
    int          rp [4];

    int n_checks = 0;
    int n_fail   = 0;

    int mon_rl = 0;
    int mon_k = 0;
    int mon_str = 0;
    int stalled = 0;
    int stall_buf = 0;
    int stall_cnt = 0;

    typedef struct {
        logic       valid;
        logic [7:0] pixel;
        logic [3:0] exp_wr;
        logic [3:0] exp_rd;
        logic       exp_ready;
    } vec_t;

    vec_t tbl[$];

    window_controller #(.IMAGE_WIDTH(W), .NUM_LB(4)) dut (
        .clk            (clk),
        .rst            (rst),
        .i_pixel        (i_pixel),
        .i_pixel_valid  (i_pixel_valid),
        .o_pixel_ready  (o_pixel_ready),
        .o_lb_wr_valid  (o_lb_wr_valid),
        .o_lb_rd        (o_lb_rd),
        .i_lb_data0     (lb_data[0]),
        .i_lb_data1     (lb_data[1]),
        .i_lb_data2     (lb_data[2]),
        .i_lb_data3     (lb_data[3]),
        .o_window       (o_window),
        .o_window_valid (o_window_valid),
        .o_line_done    (o_line_done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Behavioural line buffers: write/read pointers wrap at W, reset with rst
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int b = 0; b < 4; b++) begin
                wp[b] <= 0;
                rp[b] <= 0;
            end
        end else begin
            for (int b = 0; b < 4; b++) begin
                if (o_lb_wr_valid[b]) begin
                    mem[b][wp[b]] <= i_pixel;
                    wp[b] <= (wp[b] + 1) % W;
                end
                if (o_lb_rd[b]) begin
                    rp[b] <= (rp[b] + 1) % W;
                end
            end
        end
    end

    always_comb begin
        for (int b = 0; b < 4; b++) begin
            lb_data[b] = {mem[b][rp[b]], mem[b][(rp[b] + 1) % W], mem[b][(rp[b] + 2) % W]};
        end
    end

    function automatic logic [7:0] pix(input int r, input int c);
        return 8'(16 * r + c);
    endfunction

    function automatic logic [71:0] win(input int r, input int k);
        return {pix(r, k), pix(r, k + 1), pix(r, k + 2),
                pix(r + 1, k), pix(r + 1, k + 1), pix(r + 1, k + 2),
                pix(r + 2, k), pix(r + 2, k + 1), pix(r + 2, k + 2)};
    endfunction

    function automatic logic [3:0] rd_pat(input int s);
        logic [3:0] p;
        case (s % 4)
            0:       p = 4'b0111;
            1:       p = 4'b1110;
            2:       p = 4'b1101;
            default: p = 4'b1011;
        endcase
        return p;
    endfunction

    task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Accept one pixel, waiting (bounded) while the source is back-pressured
    task automatic push(input logic [7:0] p);
        int g;
        i_pixel_valid = 1'b1;
        i_pixel = p;
        g = 0;
        #1;
        while (!o_pixel_ready && g < 100) begin
            @(posedge clk);
            #1;
            g++;
        end
        check("push_ready", (g < 100) ? 72'd1 : 72'd0, 72'd1);
        @(posedge clk);
        #1;
    endtask

    task automatic push_line(input int row);
        for (int c = 0; c < W; c++) begin
            push(pix(row, c));
        end
        i_pixel_valid = 1'b0;
    endtask

    task automatic wait_rl(input int target, input int limit);
        int g;
        g = 0;
        while (mon_rl < target && g < limit) begin
            @(posedge clk);
            #1;
            g++;
        end
        check("lines_read", 72'(mon_rl), 72'(target));
    endtask

    // Window, read-strobe and stall monitor sampled on the falling edge
    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                mon_rl = 0;
                mon_k = 0;
                mon_str = 0;
                stalled = 0;
            end else begin
                if (o_window_valid) begin
                    check("window", o_window, win(mon_rl, mon_k));
                    mon_k++;
                end
                if (o_lb_rd != 4'b0000) begin
                    check("rd_pattern", 72'(o_lb_rd), 72'(rd_pat(mon_rl)));
                    mon_str++;
                end
                if (o_line_done) begin
                    check("valid_count", 72'(mon_k), 72'd6);
                    check("strobe_count", 72'(mon_str), 72'(W));
                    check("ready_after_read", 72'(o_pixel_ready), 72'd1);
                    mon_rl++;
                    mon_k = 0;
                    mon_str = 0;
                end
                if (!o_pixel_ready) begin
                    check("stall_no_write", 72'(o_lb_wr_valid), 72'd0);
                    stalled = 1;
                    stall_buf = mon_rl % 4;
                    stall_cnt++;
                end else if (stalled != 0 && o_lb_wr_valid != 4'b0000) begin
                    check("freed_buffer", 72'(o_lb_wr_valid), 72'(4'b0001 << stall_buf));
                    stalled = 0;
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        int g;
        rst = 1'b1;
        i_pixel_valid = 1'b0;
        i_pixel = 8'd0;

        // Build the two-line fill table, with one idle slot inside each line
        for (int r = 0; r < 2; r++) begin
            for (int c = 0; c < W; c++) begin
                if (c == 4) begin
                    tbl.push_back('{1'b0, 8'hff, 4'b0000, 4'b0000, 1'b1});
                end
                tbl.push_back('{1'b1, pix(r, c), (r == 0) ? 4'b0001 : 4'b0010, 4'b0000, 1'b1});
            end
        end

        #1;
        check("rst_window", o_window, 72'd0);
        check("rst_wvalid", 72'(o_window_valid), 72'd0);
        check("rst_done", 72'(o_line_done), 72'd0);
        check("rst_lb_rd", 72'(o_lb_rd), 72'd0);
        check("rst_ready", 72'(o_pixel_ready), 72'd1);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;

        foreach (tbl[i]) begin
            i_pixel_valid = tbl[i].valid;
            i_pixel = tbl[i].pixel;
            #1;
            check("fill_wr_valid", 72'(o_lb_wr_valid), 72'(tbl[i].exp_wr));
            check("fill_lb_rd", 72'(o_lb_rd), 72'(tbl[i].exp_rd));
            check("fill_ready", 72'(o_pixel_ready), 72'(tbl[i].exp_ready));
            check("fill_win_valid", 72'(o_window_valid), 72'd0);
            @(posedge clk);
            #1;
        end

        // Third line starts the first read
        push_line(2);
        g = 0;
        while (o_lb_rd == 4'b0000 && g < 6) begin
            @(posedge clk);
            #1;
            g++;
        end
        check("read_start", 72'(o_lb_rd), 72'(4'b0111));
        g = 0;
        while (!o_line_done && g < 20) begin
            @(posedge clk);
            #1;
            g++;
        end
        check("line_done_seen", 72'(o_line_done), 72'd1);
        @(posedge clk);
        #1;
        check("done_pulse", 72'(o_line_done), 72'd0);
        check("hold_valid", 72'(o_window_valid), 72'd0);
        check("window_hold", o_window, win(0, 5));
        @(posedge clk);
        #1;
        check("no_read_two_lines", 72'(o_lb_rd), 72'd0);

        // Reset in the middle of a line with a pixel pending
        push(pix(3, 0));
        push(pix(3, 1));
        i_pixel_valid = 1'b1;
        i_pixel = pix(3, 2);
        rst = 1'b1;
        #1;
        check("mid_rst_window", o_window, 72'd0);
        check("mid_rst_wvalid", 72'(o_window_valid), 72'd0);
        check("mid_rst_done", 72'(o_line_done), 72'd0);
        check("mid_rst_lb_rd", 72'(o_lb_rd), 72'd0);
        check("mid_rst_wr", 72'(o_lb_wr_valid), 72'd0);
        check("mid_rst_ready", 72'(o_pixel_ready), 72'd1);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Continuous six-line stream from a clean start
        i_pixel = pix(0, 0);
        i_pixel_valid = 1'b1;
        #1;
        check("wr_sel_after_reset", 72'(o_lb_wr_valid), 72'(4'b0001));
        @(posedge clk);
        #1;
        for (int c = 1; c < W; c++) begin
            push(pix(0, c));
        end
        for (int r = 1; r < 6; r++) begin
            push_line(r);
        end
        i_pixel_valid = 1'b0;
        wait_rl(4, 200);
        check("stall_seen", (stall_cnt > 0) ? 72'd1 : 72'd0, 72'd1);

        // Line written in the same cycle as a line finishes reading
        push_line(6);
        g = 0;
        while (o_lb_rd == 4'b0000 && g < 6) begin
            @(posedge clk);
            #1;
            g++;
        end
        check("simul_read_start", 72'(o_lb_rd), 72'(4'b0111));
        push_line(7);
        #1;
        check("simul_ready", 72'(o_pixel_ready), 72'd1);
        check("simul_done", 72'(o_line_done), 72'd1);
        check("simul_idle", 72'(o_lb_rd), 72'd0);
        @(posedge clk);
        #1;
        check("simul_restart", 72'(o_lb_rd), 72'(4'b1110));
        wait_rl(6, 100);
        repeat (3) @(posedge clk);
        #1;
        check("final_idle", 72'(o_lb_rd), 72'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
